// File: rtl/oddeven_sort_engine_pkg.sv
// Shared types and helpers for the odd-even transposition sorter.
package oddeven_sort_engine_pkg;

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_e;

  function automatic int phase_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Operands arrive zero-extended; flipping bit w-1 turns a two's complement
  // ordering into a plain unsigned one.
  function automatic logic ranks_after(input logic [63:0] a, input logic [63:0] b,
                                       input int w, input bit sgn, input logic desc);
    logic [63:0] ka, kb;
    ka = a;
    kb = b;
    if (sgn) begin
      ka[w-1] = ~ka[w-1];
      kb[w-1] = ~kb[w-1];
    end
    return desc ? (ka < kb) : (ka > kb);
  endfunction

endpackage

// File: rtl/oddeven_sort_engine_if.sv
// Job input / result output handshake bundle for oddeven_sort_engine.
interface oddeven_sort_engine_if
  import oddeven_sort_engine_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 16
);
  localparam int PW = phase_w(N);

  logic          in_valid;
  logic          in_ready;
  logic [N*W-1:0] in_data;
  logic          in_desc;
  logic          out_valid;
  logic          out_ready;
  logic [N*W-1:0] out_data;
  logic [PW-1:0] out_phases;

  modport master (
    output in_valid, in_data, in_desc, out_ready,
    input  in_ready, out_valid, out_data, out_phases
  );

  modport slave (
    input  in_valid, in_data, in_desc, out_ready,
    output in_ready, out_valid, out_data, out_phases
  );
endinterface

// File: rtl/oddeven_sort_engine_cmp_swap.sv
// One compare-exchange element; equal values never swap so the sort is stable.
module oddeven_sort_engine_cmp_swap
  import oddeven_sort_engine_pkg::*;
#(
  parameter int W      = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         desc,
  input  logic         en,
  output logic [W-1:0] lo_lane,
  output logic [W-1:0] hi_lane,
  output logic         swapped
);
  assign swapped = en && ranks_after(64'(a), 64'(b), W, SIGNED, desc);
  assign lo_lane = swapped ? b : a;
  assign hi_lane = swapped ? a : b;
endmodule

// File: rtl/oddeven_sort_engine.sv
// Sequential odd-even transposition sorter, one phase per clock.
// Define SORT_EARLY_EXIT_EN to stop after two consecutive swap-free phases.
module oddeven_sort_engine
  import oddeven_sort_engine_pkg::*;
#(
  parameter int N      = 5,
  parameter int W      = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  oddeven_sort_engine_if.slave  io,
  output logic                  busy
);
  localparam int PW = phase_w(N);

  state_e              state, state_nxt;
  logic [N-1:0][W-1:0] lanes, lanes_nxt;
  logic [N-2:0][W-1:0] lo_w, hi_w;
  logic [N-2:0]        swp;
  logic                desc_q;
  logic [PW-1:0]       phase_cnt;
  logic                last_phase;
  logic                accept;

  assign accept       = io.in_valid && io.in_ready;
  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign busy         = (state != IDLE);

  // Pair i (lanes i, i+1) is active on phases with matching parity.
  for (genvar i = 0; i < N-1; i++) begin : g_pair
    oddeven_sort_engine_cmp_swap #(.W(W), .SIGNED(SIGNED)) u_cs (
      .a       (lanes[i]),
      .b       (lanes[i+1]),
      .desc    (desc_q),
      .en      (phase_cnt[0] == 1'(i % 2)),
      .lo_lane (lo_w[i]),
      .hi_lane (hi_w[i]),
      .swapped (swp[i])
    );
  end

  always_comb begin
    lanes_nxt = lanes;
    for (int k = 0; k < N-1; k++) begin
      if (swp[k]) begin
        lanes_nxt[k]   = lo_w[k];
        lanes_nxt[k+1] = hi_w[k];
      end
    end
  end

`ifdef SORT_EARLY_EXIT_EN
  logic prev_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              prev_zero <= 1'b0;
    else if (accept)         prev_zero <= 1'b0;
    else if (state == SORT)  prev_zero <= ~|swp;
  end

  assign last_phase = (phase_cnt == PW'(N-1)) || (prev_zero && ~|swp);
`else
  assign last_phase = (phase_cnt == PW'(N-1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (io.in_valid)  state_nxt = SORT;
      SORT:    if (last_phase)   state_nxt = DONE;
      DONE:    if (io.out_ready) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Result registers load only on the final phase, so they stay put in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes         <= '0;
      desc_q        <= 1'b0;
      phase_cnt     <= '0;
      io.out_data   <= '0;
      io.out_phases <= '0;
    end else if (accept) begin
      lanes     <= io.in_data;
      desc_q    <= io.in_desc;
      phase_cnt <= '0;
    end else if (state == SORT) begin
      lanes     <= lanes_nxt;
      phase_cnt <= phase_cnt + PW'(1);
      if (last_phase) begin
        io.out_data   <= lanes_nxt;
        io.out_phases <= phase_cnt + PW'(1);
      end
    end
  end
endmodule
